// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding and the access-size decode used by both the store and load paths.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Reserved encodings 011/110/111 fall through to a full-word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the control FSM (master) and the
// load/store unit (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a memory word (little-endian).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        lane_b = rdata[8*addr_lo +: 8];
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sext   = ~funct3[2];
        case (f3_size(funct3))
            SZ_B:    data = {{24{sext & lane_b[7]}}, lane_b};
            SZ_H:    data = {{16{sext & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-wide memory cycles, read-modify-write for SB/SH.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return rsp_fault without a memory cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state, state_nxt;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              fault_q;

    logic              accept;
    logic              misalign;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign accept = bus.req_valid && (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (f3_size(bus.req_funct3))
            SZ_H:    misalign = bus.req_addr[0];
            SZ_W:    misalign = |bus.req_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    // Sub-word store: drop the new lane into the word just read back.
    always_comb begin
        merged = mem_rdata;
        case (f3_size(funct3_q))
            SZ_B:    merged[8*addr_q[1:0] +: 8]  = wdata_q[7:0];
            SZ_H:    merged[16*addr_q[1] +: 16] = wdata_q[15:0];
            default: merged = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                fault_q  <= misalign;
            end
            if (state == ST_CAPT) begin
                if (write_q) merge_q <= merged;
                else         rdata_q <= load_data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_fault = 1'b0;
        bus.rsp_rdata = rdata_q;
        mem_we        = 1'b0;
        mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata     = (f3_size(funct3_q) == SZ_W) ? wdata_q : merge_q;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (misalign)
                        state_nxt = ST_DONE;
                    else if (bus.req_write && (f3_size(bus.req_funct3) == SZ_W))
                        state_nxt = ST_WRITE;
                    else
                        state_nxt = ST_READ;
                end
            end
            ST_READ:  state_nxt = ST_CAPT;
            ST_CAPT:  state_nxt = write_q ? ST_WRITE : ST_DONE;
            ST_WRITE: begin
                mem_we    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_fault = fault_q;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory has no range check; flag accesses beyond its depth in simulation.
    always_ff @(posedge clk) begin
        if (reset && (state == ST_READ || state == ST_WRITE))
            assert ({2'b00, addr_q[ADDR_W-1:2]} < ADDR_W'(MEM_WORDS));
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses/writes; a negedge monitor pops and compares them.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:2]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t exp_q[$];
    wr_t  wr_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    int   n_abort = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: accepts, memory writes and responses, all sampled on the falling edge.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        int   a;
        if (!reset) begin
            acc_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                acc_q.push_back(cyc);
                n_acc++;
            end
            if (mem_we) begin
                if (wr_q.size() == 0) fail_now("unexpected_mem_we");
                else begin
                    w = wr_q.pop_front();
                    check32("wr_addr", mem_addr, w.addr);
                    check32("wr_data", mem_wdata, w.data);
                end
            end
            if (bus.rsp_valid) begin
                n_rsp++;
                check32("ready_in_done", {31'b0, bus.req_ready}, 32'd0);
                if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("unexpected_rsp");
                else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check32("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check32("rsp_fault", {31'b0, bus.rsp_fault}, {31'b0, e.fault});
                    check32("rsp_latency", 32'(cyc - a), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_fault, input int lat, input logic has_wr,
                         input logic [31:0] wr_data, input logic hold, input logic push);
        rsp_t e;
        wr_t  w;
        bit   ok;
        if (push) begin
            e.rdata = exp_rdata;
            e.fault = exp_fault;
            e.lat   = lat;
            exp_q.push_back(e);
            if (has_wr) begin
                w.addr = {addr[31:2], 2'b00};
                w.data = wr_data;
                wr_q.push_back(w);
            end
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("req_ready_timeout");
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[8]  = 32'h80FF7F01;
        mem[12] = 32'h11223344;
        mem[16] = 32'hCAFEF00D;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check32("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check32("rst_rsp_fault", {31'b0, bus.rsp_fault}, 32'd0);
        check32("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // SW then LW of the same word
        issue(1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF, 0, 1);
        issue(0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, 32'h0, 0, 1);

        // Lane select and extension on 0x80FF7F01
        issue(0, F3_B,  32'h21, 32'h0, 32'h0000007F, 0, 3, 0, 32'h0, 0, 1);
        issue(0, F3_B,  32'h22, 32'h0, 32'hFFFFFFFF, 0, 3, 0, 32'h0, 0, 1);
        issue(0, F3_BU, 32'h23, 32'h0, 32'h00000080, 0, 3, 0, 32'h0, 0, 1);
        issue(0, F3_H,  32'h22, 32'h0, 32'hFFFF80FF, 0, 3, 0, 32'h0, 0, 1);
        issue(0, F3_HU, 32'h20, 32'h0, 32'h00007F01, 0, 3, 0, 32'h0, 0, 1);

        // Read-modify-write stores; rsp_rdata keeps the last load value
        issue(1, F3_B, 32'h31, 32'h123456AA, 32'h00007F01, 0, 4, 1, 32'h1122AA44, 0, 1);
        issue(1, F3_H, 32'h32, 32'h5555BEEF, 32'h00007F01, 0, 4, 1, 32'hBEEFAA44, 0, 1);
        issue(0, F3_W, 32'h30, 32'h0, 32'hBEEFAA44, 0, 3, 0, 32'h0, 0, 1);

        // Back-to-back with req_valid held between requests
        issue(0, F3_W,  32'h20, 32'h0, 32'h80FF7F01, 0, 3, 0, 32'h0, 1, 1);
        issue(1, F3_W,  32'h50, 32'h01020304, 32'h80FF7F01, 0, 2, 1, 32'h01020304, 1, 1);
        issue(0, F3_HU, 32'h52, 32'h0, 32'h00000102, 0, 3, 0, 32'h0, 1, 1);
        issue(0, F3_B,  32'h53, 32'h0, 32'h00000001, 0, 3, 0, 32'h0, 0, 1);

        // Reset while an SB sits in CAPT
        issue(1, F3_B, 32'h54, 32'h000000EE, 32'h0, 0, 4, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_abort++;
        #1;
        check32("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check32("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check32("abort_mem_we", {31'b0, mem_we}, 32'd0);
        check32("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        issue(0, F3_W, 32'h50, 32'h0, 32'h01020304, 0, 3, 0, 32'h0, 0, 1);

        // Reserved funct3 behaves as a word access
        issue(0, 3'b011, 32'h40, 32'h0, 32'hCAFEF00D, 0, 3, 0, 32'h0, 0, 1);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, F3_W, 32'h42, 32'h0, 32'hCAFEF00D, 1, 1, 0, 32'h0, 0, 1);
`else
        issue(0, F3_W, 32'h42, 32'h0, 32'hCAFEF00D, 0, 3, 0, 32'h0, 0, 1);
`endif

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && wr_q.size() == 0) break;
            @(negedge clk);
        end
        check32("pending_rsp", 32'(exp_q.size()), 32'd0);
        check32("pending_wr", 32'(wr_q.size()), 32'd0);
        check32("rsp_count", 32'(n_rsp), 32'(n_acc - n_abort));
        check32("mem_0x30", mem[12], 32'hBEEFAA44);
        check32("mem_0x54", mem[21], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
